// File: rtl/imem_loader_pkg.sv
// Shared constants, FSM state type and length clamp for the boot-time imem loader.
package imem_loader_pkg;

    localparam int ADDR_W         = 12;
    localparam int DATA_W         = 32;
    localparam int DEPTH          = 4096;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [ADDR_W:0] DEPTH_LEN = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Requests longer than the memory are trimmed so the address never wraps.
    function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] req_len);
        logic [ADDR_W:0] res;
        if (req_len > DEPTH_LEN) begin
            res = DEPTH_LEN;
        end else begin
            res = req_len;
        end
        return res;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian 8->32 packer: byte k of a word lands in bits [8k+7:8k].
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    output logic              word_full,
    output logic [DATA_W-1:0] word
);

    logic [1:0]        cnt_r;
    logic [DATA_W-1:0] pack_r;
    logic [DATA_W-1:0] insert_s;

    // Current pack with the incoming byte dropped into its lane.
    always_comb begin
        insert_s                       = pack_r;
        insert_s[{cnt_r, 3'b000} +: 8] = byte_in;
    end

    assign word_full = accept && (cnt_r == 2'd3);
    assign word      = insert_s;

    // Byte counter and packing register; the counter wraps after the fourth byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r  <= 2'd0;
            pack_r <= {DATA_W{1'b0}};
        end else if (clear) begin
            cnt_r  <= 2'd0;
            pack_r <= {DATA_W{1'b0}};
        end else if (accept) begin
            cnt_r  <= cnt_r + 2'd1;
            pack_r <= insert_s;
        end else begin
            cnt_r  <= cnt_r;
            pack_r <= pack_r;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a byte stream into words, writes them to imem from address 0
// and keeps the processor in reset until the requested length has been written.
module imem_loader
    import imem_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_wren,
    output logic [ADDR_W-1:0] imem_address,
    output logic [DATA_W-1:0] imem_data,
    output logic              proc_reset,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded
);

    state_t            state_r;
    logic [ADDR_W:0]   len_q_r;
    logic [ADDR_W-1:0] word_addr_r;
    logic [ADDR_W:0]   words_loaded_r;
    logic              rx_ready_r;
    logic              imem_wren_r;
    logic [ADDR_W-1:0] imem_address_r;
    logic [DATA_W-1:0] imem_data_r;
    logic              proc_reset_r;
    logic              busy_r;
    logic              done_r;

    logic              accept_s;
    logic              clear_s;
    logic              word_full_s;
    logic [DATA_W-1:0] word_s;
    logic [ADDR_W:0]   len_clamped_s;

    assign accept_s      = rx_valid && rx_ready_r;
    assign clear_s       = (state_r == ST_IDLE) && start;
    assign len_clamped_s = clamp_len(len);

    imem_loader_byte_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear_s),
        .accept    (accept_s),
        .byte_in   (rx_data),
        .word_full (word_full_s),
        .word      (word_s)
    );

    // Load sequencer with all outputs registered.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            len_q_r        <= {(ADDR_W + 1){1'b0}};
            word_addr_r    <= {ADDR_W{1'b0}};
            words_loaded_r <= {(ADDR_W + 1){1'b0}};
            rx_ready_r     <= 1'b0;
            imem_wren_r    <= 1'b0;
            imem_address_r <= {ADDR_W{1'b0}};
            imem_data_r    <= {DATA_W{1'b0}};
            proc_reset_r   <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r      <= 1'b0;
                    imem_wren_r <= 1'b0;
                    if (start) begin
                        len_q_r        <= len_clamped_s;
                        word_addr_r    <= {ADDR_W{1'b0}};
                        words_loaded_r <= {(ADDR_W + 1){1'b0}};
                        proc_reset_r   <= 1'b1;
                        if (len_clamped_s == {(ADDR_W + 1){1'b0}}) begin
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            busy_r     <= 1'b0;
                            rx_ready_r <= 1'b0;
                        end else begin
                            state_r    <= ST_RECV;
                            busy_r     <= 1'b1;
                            rx_ready_r <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RECV: begin
                    // The fourth byte is folded in here so imem_data is complete in WRITE.
                    if (word_full_s) begin
                        state_r        <= ST_WRITE;
                        rx_ready_r     <= 1'b0;
                        imem_wren_r    <= 1'b1;
                        imem_address_r <= word_addr_r;
                        imem_data_r    <= word_s;
                    end else begin
                        state_r <= ST_RECV;
                    end
                end
                ST_WRITE: begin
                    imem_wren_r    <= 1'b0;
                    word_addr_r    <= word_addr_r + {{(ADDR_W - 1){1'b0}}, 1'b1};
                    words_loaded_r <= words_loaded_r + {{ADDR_W{1'b0}}, 1'b1};
                    if ((words_loaded_r + {{ADDR_W{1'b0}}, 1'b1}) == len_q_r) begin
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        rx_ready_r <= 1'b0;
                    end else begin
                        state_r    <= ST_RECV;
                        rx_ready_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_r       <= 1'b0;
                    proc_reset_r <= 1'b0;
                    busy_r       <= 1'b0;
                    rx_ready_r   <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rx_ready_r  <= 1'b0;
                    imem_wren_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_r;
    assign imem_wren    = imem_wren_r;
    assign imem_address = imem_address_r;
    assign imem_data    = imem_data_r;
    assign proc_reset   = proc_reset_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign words_loaded = words_loaded_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a queue of expected (address, word) writes built
// from the byte stream is checked against every imem write, plus literal spot checks.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_wren;
    logic [ADDR_W-1:0] imem_address;
    logic [DATA_W-1:0] imem_data;
    logic              proc_reset;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   words_loaded;

    imem_loader dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .len          (len),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_wren    (imem_wren),
        .imem_address (imem_address),
        .imem_data    (imem_data),
        .proc_reset   (proc_reset),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic prev_wren = 1'b0;
    logic [ADDR_W-1:0] exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [ADDR_W-1:0] log_addr[$];
    logic [DATA_W-1:0] log_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected writes: word i is bytes 4i..4i+3 little-endian at address i.
    task automatic expect_words(input logic [7:0] bq[$], input int nwords);
        for (int i = 0; i < nwords; i++) begin
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back({bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]});
        end
    endtask

    function automatic logic [7:0] big_byte(input int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // Compare process: every imem write must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset) begin
            if (done) done_cnt++;
            if (imem_wren) begin
                wr_cnt++;
                log_addr.push_back(imem_address);
                log_data.push_back(imem_data);
                check("wren_one_cycle", 32'(prev_wren), 32'd0);
                check("rx_ready_low_in_write", 32'(rx_ready), 32'd0);
                check("busy_in_write", 32'(busy), 32'd1);
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%03h data 0x%08h expected no write",
                             imem_address, imem_data);
                end else begin
                    check("wr_addr", 32'(imem_address), 32'(exp_addr_q.pop_front()));
                    check("wr_data", imem_data, exp_data_q.pop_front());
                end
            end
            prev_wren = imem_wren;
        end else begin
            prev_wren = 1'b0;
        end
    end

    task automatic start_load(input int l);
        @(negedge clock);
        start = 1'b1;
        len   = (ADDR_W + 1)'(l);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Hold the byte until the loader takes it; rx_ready sampled at negedge is what the next edge sees.
    task automatic send_byte(input logic [7:0] b);
        int   waited;
        logic acc;
        waited = 0;
        @(negedge clock);
        rx_valid = 1'b1;
        rx_data  = b;
        acc      = rx_ready;
        while (!acc && waited < 50) begin
            @(negedge clock);
            acc = rx_ready;
            waited++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL byte_accept_timeout: got rx_ready=0 for 50 cycles expected 1 (byte 0x%02h)", b);
            rx_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            rx_valid = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] bq[$];
        int wr0, dn0;

        // 1. reset
        repeat (3) @(negedge clock);
        check("rst_proc_reset", 32'(proc_reset), 32'd1);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_outputs_zero",
              32'({rx_ready, imem_wren, busy, done}), 32'd0);
        check("rst_address", 32'(imem_address), 32'd0);
        check("rst_data", imem_data, 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        check("rst_proc_reset_after", 32'(proc_reset), 32'd1);

        // 2. two words, no stalls
        bq = '{8'h13, 8'h00, 8'h20, 8'h00, 8'h04, 8'h00, 8'h00, 8'h08};
        expect_words(bq, 2);
        log_addr.delete(); log_data.delete();
        dn0 = done_cnt;
        start_load(2);
        check("t2_busy", 32'(busy), 32'd1);
        foreach (bq[i]) send_byte(bq[i]);
        wait_done("t2_done", 4);
        check("t2_words_loaded", 32'(words_loaded), 32'd2);
        check("t2_proc_reset_in_done", 32'(proc_reset), 32'd1);
        check("t2_busy_in_done", 32'(busy), 32'd0);
        @(negedge clock);
        check("t2_proc_reset_released", 32'(proc_reset), 32'd0);
        check("t2_done_once", 32'(done_cnt - dn0), 32'd1);
        check("t2_first_addr", 32'(log_addr[0]), 32'd0);
        check("t2_first_data", log_data[0], 32'h00200013);
        check("t2_second_addr", 32'(log_addr[1]), 32'd1);
        check("t2_second_data", log_data[1], 32'h08000004);

        // start outside IDLE is ignored: a second start mid-load must not shorten the load
        // 3. one word with rx_valid gaps
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        expect_words(bq, 1);
        log_addr.delete(); log_data.delete();
        wr0 = wr_cnt;
        start_load(1);
        foreach (bq[i]) begin
            send_byte(bq[i]);
            idle(2);
        end
        wait_done("t3_done", 6);
        @(negedge clock);
        check("t3_one_write", 32'(wr_cnt - wr0), 32'd1);
        check("t3_data", log_data[0], 32'hDDCCBBAA);
        check("t3_addr", 32'(log_addr[0]), 32'd0);

        // 4. zero length
        wr0 = wr_cnt;
        start_load(0);
        wait_done("t4_done", 2);
        @(negedge clock);
        check("t4_no_write", 32'(wr_cnt - wr0), 32'd0);
        check("t4_proc_reset", 32'(proc_reset), 32'd0);

        // 5. clamped length
        for (int w = 0; w < DEPTH; w++) begin
            exp_addr_q.push_back(ADDR_W'(w));
            exp_data_q.push_back({big_byte(4*w+3), big_byte(4*w+2), big_byte(4*w+1), big_byte(4*w)});
        end
        log_addr.delete(); log_data.delete();
        wr0 = wr_cnt;
        start_load(5000);
        for (int i = 0; i < 4 * DEPTH; i++) begin
            send_byte(big_byte(i));
            if (i == 10) begin
                start = 1'b1;
                len   = 13'd1;
            end else if (i == 11) begin
                start = 1'b0;
            end
        end
        wait_done("t5_done", 4);
        check("t5_words_loaded", 32'(words_loaded), 32'd4096);
        check("t5_write_count", 32'(wr_cnt - wr0), 32'd4096);
        check("t5_last_addr", 32'(log_addr[log_addr.size()-1]), 32'h00000FFF);
        @(negedge clock);

        // 6. reset during word 3
        bq.delete();
        for (int i = 0; i < 20; i++) bq.push_back(8'(8'h40 + i));
        expect_words(bq, 3);
        wr0 = wr_cnt;
        start_load(5);
        for (int i = 0; i < 14; i++) send_byte(bq[i]);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("t6_proc_reset", 32'(proc_reset), 32'd1);
        check("t6_idle_outputs", 32'({rx_ready, imem_wren, busy, done}), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t6_writes_before_reset", 32'(wr_cnt - wr0), 32'd3);
        check("t6_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        bq = '{8'h78, 8'h56, 8'h34, 8'h12};
        expect_words(bq, 1);
        log_addr.delete(); log_data.delete();
        start_load(1);
        foreach (bq[i]) send_byte(bq[i]);
        wait_done("t6_done", 4);
        check("t6_new_addr", 32'(log_addr[0]), 32'd0);
        check("t6_new_data", log_data[0], 32'h12345678);
        @(negedge clock);
        check("t6_proc_reset_released", 32'(proc_reset), 32'd0);
        check("final_queue_empty", 32'(exp_addr_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader upstream of the processor/imem wrapper.
- Receives a byte stream over a valid/ready interface and packs bytes little-endian into 32-bit words.
- Writes each packed word into the imem write port at sequential addresses starting from 0.
- Holds the processor in reset until the requested number of words has been written.

Parameters:
- ADDR_W, 12, imem word-address width.
- DATA_W, 32, imem word width; fixed at 4 bytes per word.
- DEPTH, 4096, number of imem words; load lengths above this are clamped.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- len  in  ADDR_W+1  number of words to load; sampled together with start.
- rx_valid  in  1  byte-stream valid.
- rx_data  in  8  byte-stream data.
- rx_ready  out  1  loader can accept a byte.
- imem_wren  out  1  imem write enable, one cycle per word.
- imem_address  out  ADDR_W  imem word address.
- imem_data  out  DATA_W  packed word to write.
- proc_reset  out  1  active-high reset to the processor and regfile.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.
- words_loaded  out  ADDR_W+1  count of words written in the current or last load.

Behaviour:
- Reset (reset=0, async): state=IDLE; rx_ready=0, imem_wren=0, imem_address=0, imem_data=0, busy=0, done=0, words_loaded=0, proc_reset=1.
  - Byte counter, word address and packing register are cleared.
  - proc_reset stays 1 until the first completed load.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start=1 latches len_q = min(len, DEPTH), clears the byte counter, word address and words_loaded, and sets proc_reset=1.
  - If len_q=0, go to DONE; otherwise go to RECV.
  - start=0 stays in IDLE; proc_reset keeps its value.
- RECV:
  - rx_ready=1 and busy=1.
  - A byte is accepted only on rx_valid & rx_ready.
  - Accepted byte k (k=0..3) goes to pack[8k+7:8k], so the first byte is the LSB.
  - After the 4th accepted byte, go to WRITE; the byte counter wraps to 0.
  - rx_valid=0 means the state holds; there is no timeout.
- WRITE (exactly 1 cycle):
  - rx_ready=0, imem_wren=1, imem_address=word_addr, imem_data=pack.
  - word_addr and words_loaded increment.
  - If words_loaded+1 == len_q, go to DONE; otherwise go to RECV.
  - Latency: write occurs the cycle after the 4th byte is accepted.
  - Throughput: at most 1 word per 5 cycles.
- DONE (1 cycle):
  - done=1, busy=0, rx_ready=0.
  - proc_reset drops to 0 on the next edge, when the state returns to IDLE.
- Outputs outside WRITE: imem_wren=0. imem_address and imem_data hold their last values.
- start outside IDLE: ignored, with no effect on len_q.
- Address wrap: cannot occur, because len is clamped to DEPTH. The final address is len_q-1.
- Reset mid-load: async return to the reset state.
  - The partial word is discarded and never written.
  - Words already written remain in imem.
  - proc_reset=1.
- rx_valid arriving together with the WRITE→RECV transition: not accepted until rx_ready=1 in RECV. The upstream source must hold the byte.

Decomposition:
- Shared package contents:
  - state enum (IDLE, RECV, WRITE, DONE)
  - ADDR_W, DATA_W, DEPTH
  - BYTES_PER_WORD=4
- One sub-module: byte_packer.
  - Contains the 8→32 shift/insert register and the 2-bit byte counter.
  - Inputs: clear, accept.
  - Outputs: word_full, word.
- The FSM, address counter and proc_reset flop stay in imem_loader.

Test Plan:
1. Reset low for 3 cycles, then high → all outputs 0 except proc_reset=1; rx_ready=0.
2. start with len=2, then bytes 0x13,0x00,0x20,0x00 and 0x04,0x00,0x00,0x08 (no stalls), then check done and proc_reset.
   - First write: imem_address=0, data=0x00200013.
   - Second write: imem_address=1, data=0x08000004.
   - done pulses once; words_loaded=2; proc_reset=0 the following cycle.
3. len=1 with rx_valid toggling 1,0,0,1,… between bytes 0xAA,0xBB,0xCC,0xDD → exactly one write, data=0xDDCCBBAA, address 0; no byte lost or duplicated.
4. start with len=0 → done pulses within 2 cycles; imem_wren never asserts; proc_reset=0 afterwards.
5. start with len=5000 → len_q=4096; after 16384 bytes the last write has address 0xFFF and done pulses.
6. Reset asserted after 2 bytes of word 3 → imem_wren never fires for address 3; proc_reset=1.
   - A new start (len=1) then writes address 0 with the freshly sent bytes.
